// File: rtl/trolley_system_pkg.sv
// Shared types and PIO register map for the trolley button service master.
// Optional debounce lockout is enabled by defining TROLLEY_BTN_LOCKOUT_EN.
package trolley_system_pkg;

  typedef enum logic [2:0] {
    ST_INIT_MASK,
    ST_IDLE,
    ST_RD_CAP,
    ST_WAIT_CAP,
    ST_CLR_CAP,
    ST_RD_DAT,
    ST_WAIT_DAT,
    ST_EMIT
  } btn_state_e;

  localparam logic [1:0]  ADDR_DATA = 2'd0;
  localparam logic [1:0]  ADDR_MASK = 2'd2;
  localparam logic [1:0]  ADDR_CAP  = 2'd3;

  localparam logic [31:0] CLR_WORD  = 32'h1;
  localparam logic [31:0] MASK_WORD = 32'h1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/trolley_system_button_lockout_timer.sv
// Debounce lockout down-counter; busy while a recently accepted event is still "hot".
// Instantiated by the service master only when TROLLEY_BTN_LOCKOUT_EN is defined.
module trolley_system_button_lockout_timer #(
  parameter int unsigned LOCKOUT_CYC = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  output logic busy_o
);

  localparam int unsigned CNT_W = (LOCKOUT_CYC < 2) ? 1 : $clog2(LOCKOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CNT_W'(LOCKOUT_CYC);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/trolley_system_button_service_master.sv
// Avalon-MM master servicing the button PIO: arms irq_mask, then on irq reads/clears
// edge_capture, samples the pin and emits one valid/ready event. Macro: TROLLEY_BTN_LOCKOUT_EN.
module trolley_system_button_service_master
  import trolley_system_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned COUNT_W      = 16,
  parameter int unsigned LOCKOUT_CYC  = 50000
) (
  input  logic               clk,
  input  logic               reset,
  output logic [1:0]         avm_address,
  output logic               avm_read,
  output logic               avm_write,
  output logic [31:0]        avm_writedata,
  input  logic [31:0]        avm_readdata,
  input  logic               avm_waitrequest,
  input  logic               button_irq,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic               evt_level,
  output logic [COUNT_W-1:0] evt_count,
  output logic [7:0]         dropped_count
);

  localparam int unsigned LAT_W = (READ_LATENCY <= 2) ? 1 : $clog2(READ_LATENCY);

  btn_state_e         state_q;
  logic [1:0]         addr_q;
  logic               rd_q;
  logic               wr_q;
  logic [31:0]        wdata_q;
  logic [LAT_W-1:0]   lat_q;
  logic               valid_q;
  logic               level_q;
  logic [COUNT_W-1:0] count_q;
  logic               drop_q;
  logic               lockout_busy;
  logic               in_lockout;
  logic               unused_readdata_hi;

  assign unused_readdata_hi = ^avm_readdata[31:1];

`ifdef TROLLEY_BTN_LOCKOUT_EN
  logic       load_lockout;
  logic       drop_done;
  logic [7:0] dropped_q;

  assign load_lockout = (state_q == ST_EMIT) && evt_ready;
  assign drop_done    = (state_q == ST_CLR_CAP) && !avm_waitrequest && drop_q;

  trolley_system_button_lockout_timer #(
    .LOCKOUT_CYC(LOCKOUT_CYC)
  ) u_lockout (
    .clk   (clk),
    .reset (reset),
    .load_i(load_lockout),
    .busy_o(lockout_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      dropped_q <= '0;
    end else if (drop_done) begin
      dropped_q <= sat_inc8(dropped_q);
    end
  end

  assign dropped_count = dropped_q;
`else
  assign lockout_busy  = 1'b0;
  assign dropped_count = '0;
`endif

  // A zero-length lockout means every capture is serviced normally.
  assign in_lockout = (LOCKOUT_CYC != 0) && lockout_busy;

  // Read states spend one cycle launching the request; the clear write is launched
  // directly from the decision edge, giving irq-to-valid of 7 cycles at zero wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT_MASK;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      lat_q   <= '0;
      valid_q <= 1'b0;
      level_q <= 1'b0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT_MASK: begin
          if (!wr_q) begin
            wr_q    <= 1'b1;
            addr_q  <= ADDR_MASK;
            wdata_q <= MASK_WORD;
          end else if (!avm_waitrequest) begin
            wr_q    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (button_irq) begin
            if (in_lockout) begin
              drop_q  <= 1'b1;
              wr_q    <= 1'b1;
              addr_q  <= ADDR_CAP;
              wdata_q <= CLR_WORD;
              state_q <= ST_CLR_CAP;
            end else begin
              drop_q  <= 1'b0;
              state_q <= ST_RD_CAP;
            end
          end
        end
        ST_RD_CAP: begin
          if (!rd_q) begin
            rd_q   <= 1'b1;
            addr_q <= ADDR_CAP;
          end else if (!avm_waitrequest) begin
            rd_q    <= 1'b0;
            lat_q   <= LAT_W'(READ_LATENCY - 1);
            state_q <= ST_WAIT_CAP;
          end
        end
        ST_WAIT_CAP: begin
          if (lat_q != '0) begin
            lat_q <= lat_q - 1'b1;
          end else if (avm_readdata[0]) begin
            wr_q    <= 1'b1;
            addr_q  <= ADDR_CAP;
            wdata_q <= CLR_WORD;
            state_q <= ST_CLR_CAP;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CLR_CAP: begin
          if (!avm_waitrequest) begin
            wr_q    <= 1'b0;
            state_q <= drop_q ? ST_IDLE : ST_RD_DAT;
          end
        end
        ST_RD_DAT: begin
          if (!rd_q) begin
            rd_q   <= 1'b1;
            addr_q <= ADDR_DATA;
          end else if (!avm_waitrequest) begin
            rd_q    <= 1'b0;
            lat_q   <= LAT_W'(READ_LATENCY - 1);
            state_q <= ST_WAIT_DAT;
          end
        end
        ST_WAIT_DAT: begin
          if (lat_q != '0) begin
            lat_q <= lat_q - 1'b1;
          end else begin
            level_q <= avm_readdata[0];
            valid_q <= 1'b1;
            state_q <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (evt_ready) begin
            valid_q <= 1'b0;
            if (count_q != '1) begin
              count_q <= count_q + 1'b1;
            end
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_INIT_MASK;
      endcase
    end
  end

  assign avm_address   = addr_q;
  assign avm_read      = rd_q;
  assign avm_write     = wr_q;
  assign avm_writedata = wdata_q;
  assign evt_valid     = valid_q;
  assign evt_level     = level_q;
  assign evt_count     = count_q;

endmodule
